// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point adder/subtractor: align, add/normalise, round/pack.
// Round-to-nearest-even, Inf/NaN handling, valid/ready stream with one global stall enable.

module fp_addsub_pipe #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_W+FRAC_W:0] a,
    input  logic [EXP_W+FRAC_W:0] b,
    input  logic                  op_sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+FRAC_W:0] result,
    output logic [2:0]            flags
);

    localparam int WIDTH = 1 + EXP_W + FRAC_W;
    localparam int XW    = FRAC_W + 4;   // {hidden, frac, guard, round, sticky}
    localparam int EW    = EXP_W + 2;    // headroom for carry and overflow detection

    localparam logic [WIDTH-1:0] QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [EW-1:0]    E_ONE   = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [EW-1:0]    E_MAX   = {2'b00, {EXP_W{1'b1}}};

    function automatic logic [EW-1:0] lzc(input logic [XW-1:0] v);
        lzc = EW'(XW);
        for (int i = 0; i < XW; i++) begin
            if (v[i]) lzc = EW'(XW - 1 - i);
        end
    endfunction

    logic adv;
    assign adv      = ~(out_valid & ~out_ready);
    assign in_ready = adv;

    // ---------------- stage 1: special detect, swap, align ----------------
    logic               a_sign, b_sign, eff_sub, swap;
    logic [EXP_W-1:0]   a_exp, b_exp, l_exp, s_exp, l_eexp, s_eexp, diff;
    logic [FRAC_W-1:0]  a_frac, b_frac, l_frac, s_frac;
    logic               a_nan, b_nan, a_inf, b_inf, l_sign;
    logic [XW-1:0]      l_mant, s_ext, s_shift, s_back, s_aligned;
    logic               spec;
    logic [WIDTH-1:0]   spec_res;
    logic [2:0]         spec_flags;

    assign a_sign  = a[WIDTH-1];
    assign b_sign  = b[WIDTH-1] ^ op_sub;
    assign a_exp   = a[WIDTH-2:FRAC_W];
    assign b_exp   = b[WIDTH-2:FRAC_W];
    assign a_frac  = a[FRAC_W-1:0];
    assign b_frac  = b[FRAC_W-1:0];
    assign a_nan   = (&a_exp) & (|a_frac);
    assign b_nan   = (&b_exp) & (|b_frac);
    assign a_inf   = (&a_exp) & ~(|a_frac);
    assign b_inf   = (&b_exp) & ~(|b_frac);
    assign eff_sub = a_sign ^ b_sign;
    assign swap    = {b_exp, b_frac} > {a_exp, a_frac};

    assign l_sign  = swap ? b_sign : a_sign;
    assign l_exp   = swap ? b_exp  : a_exp;
    assign l_frac  = swap ? b_frac : a_frac;
    assign s_exp   = swap ? a_exp  : b_exp;
    assign s_frac  = swap ? a_frac : b_frac;
    assign l_eexp  = (l_exp == '0) ? EXP_ONE : l_exp;
    assign s_eexp  = (s_exp == '0) ? EXP_ONE : s_exp;
    assign diff    = l_eexp - s_eexp;

    assign l_mant    = {l_exp != '0, l_frac, 3'b000};
    assign s_ext     = {s_exp != '0, s_frac, 3'b000};
    assign s_shift   = s_ext >> diff;
    // Any bit lost by the shift makes the round-trip differ; that collapses into sticky.
    assign s_back    = s_shift << diff;
    assign s_aligned = {s_shift[XW-1:1], s_shift[0] | (s_back != s_ext)};

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        spec       = 1'b0;
        spec_res   = '0;
        spec_flags = 3'b000;
        if (a_nan | b_nan) begin
            spec       = 1'b1;
            spec_res   = QNAN;
            spec_flags = {(a_nan & ~a_frac[FRAC_W-1]) | (b_nan & ~b_frac[FRAC_W-1]), 2'b00};
        end else if (a_inf & b_inf & eff_sub) begin
            spec       = 1'b1;
            spec_res   = QNAN;
            spec_flags = 3'b100;
        end else if (a_inf) begin
            spec     = 1'b1;
            spec_res = {a_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (b_inf) begin
            spec     = 1'b1;
            spec_res = {b_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end
    end

    logic               s1_valid, s1_spec, s1_sign, s1_eff_sub;
    logic [WIDTH-1:0]   s1_spec_res;
    logic [2:0]         s1_spec_flags;
    logic [EXP_W-1:0]   s1_exp;
    logic [XW-1:0]      s1_l_mant, s1_s_mant;

    // ---------------- stage 2: add/subtract, normalise ----------------
    logic [XW:0]    sum;
    logic [EW-1:0]  exp_w, lz, lim, sh, n_exp;
    logic [XW-1:0]  n_mant;
    logic           n_sign;

    assign sum   = s1_eff_sub ? ({1'b0, s1_l_mant} - {1'b0, s1_s_mant})
                              : ({1'b0, s1_l_mant} + {1'b0, s1_s_mant});
    assign exp_w = {2'b00, s1_exp};
    assign lz    = lzc(sum[XW-1:0]);
    assign lim   = exp_w - E_ONE;

    always_comb begin
        n_sign = s1_sign;
        n_mant = '0;
        n_exp  = '0;
        sh     = '0;
        if (sum[XW]) begin
            n_mant = {sum[XW:2], sum[1] | sum[0]};
            n_exp  = exp_w + E_ONE;
        end else begin
            // Stop normalising at the minimum exponent; what remains is subnormal.
            sh     = (lz < lim) ? lz : lim;
            n_mant = sum[XW-1:0] << sh;
            n_exp  = n_mant[XW-1] ? (exp_w - sh) : '0;
            if (s1_eff_sub && (sum[XW-1:0] == '0)) n_sign = 1'b0;
        end
    end

    logic               s2_valid, s2_spec, s2_sign;
    logic [WIDTH-1:0]   s2_spec_res;
    logic [2:0]         s2_spec_flags;
    logic [EW-1:0]      s2_exp;
    logic [XW-1:0]      s2_mant;

    // ---------------- stage 3: round to nearest even, pack ----------------
    logic               g_bit, r_bit, s_bit, lsb, inc, inexact;
    logic [FRAC_W+1:0]  rnd;
    logic [EW-1:0]      f_exp;
    logic [FRAC_W-1:0]  f_frac;
    logic [WIDTH-1:0]   res3;
    logic [2:0]         flags3;

    assign lsb     = s2_mant[3];
    assign g_bit   = s2_mant[2];
    assign r_bit   = s2_mant[1];
    assign s_bit   = s2_mant[0];
    assign inc     = g_bit & (r_bit | s_bit | lsb);
    assign inexact = g_bit | r_bit | s_bit;
    assign rnd     = {1'b0, s2_mant[XW-1:3]} + {{(FRAC_W+1){1'b0}}, inc};

    always_comb begin
        f_exp  = s2_exp;
        f_frac = rnd[FRAC_W-1:0];
        if (rnd[FRAC_W+1]) begin
            f_exp  = s2_exp + E_ONE;
            f_frac = rnd[FRAC_W:1];
        end else if (rnd[FRAC_W] && (s2_exp == '0)) begin
            f_exp = E_ONE;   // subnormal rounded up into the smallest normal
        end
        if (s2_spec) begin
            res3   = s2_spec_res;
            flags3 = s2_spec_flags;
        end else if (f_exp >= E_MAX) begin
            res3   = {s2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            flags3 = 3'b011;
        end else begin
            res3   = {s2_sign, f_exp[EXP_W-1:0], f_frac};
            flags3 = {2'b00, inexact};
        end
    end

    // ---------------- pipeline registers ----------------
    // NOTE: datapath registers are not reset; the valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_spec       <= spec;
            s1_spec_res   <= spec_res;
            s1_spec_flags <= spec_flags;
            s1_sign       <= l_sign;
            s1_eff_sub    <= eff_sub;
            s1_exp        <= l_eexp;
            s1_l_mant     <= l_mant;
            s1_s_mant     <= s_aligned;
            s2_spec       <= s1_spec;
            s2_spec_res   <= s1_spec_res;
            s2_spec_flags <= s1_spec_flags;
            s2_sign       <= n_sign;
            s2_exp        <= n_exp;
            s2_mant       <= n_mant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= 3'b000;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                result <= res3;
                flags  <= flags3;
            end
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe (binary32): vector table, backpressure stream,
// and reset with operations in flight.

module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [2:0]  flags;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op_sub;
        logic [31:0] res;
        logic [2:0]  flg;
    } vec_t;

    vec_t vq[$];

    fp_addsub_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic add_vec(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                           input logic [31:0] vr, input logic [2:0] vf);
        vec_t v;
        v.a = va; v.b = vb; v.op_sub = vop; v.res = vr; v.flg = vf;
        vq.push_back(v);
    endtask

    // Presents one operation in the current cycle and waits for its result.
    task automatic run_vec(input int idx);
        int lat;
        a = vq[idx].a; b = vq[idx].b; op_sub = vq[idx].op_sub;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("v%0d latency", idx), 64'(lat), 64'd3);
        check($sformatf("v%0d result", idx), 64'(result), 64'(vq[idx].res));
        check($sformatf("v%0d flags", idx), 64'(flags), 64'(vq[idx].flg));
        @(posedge clk); #1;
    endtask

    // Eight operations back-to-back, consumer stalls for cycles 5..9.
    task automatic stream_test();
        int  issued, got, ready_low, last_out;
        logic stall;
        issued = 0; got = 0; ready_low = 0; last_out = -1;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            stall     = (cyc >= 5) && (cyc <= 9);
            out_ready = !stall;
            if (issued < 8) begin
                a = vq[issued].a; b = vq[issued].b; op_sub = vq[issued].op_sub;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check($sformatf("stream c%0d in_ready", cyc), 64'(in_ready), 64'(!stall));
            if (!in_ready) ready_low++;
            if (out_valid && out_ready) begin
                check($sformatf("stream r%0d result", got), 64'(result), 64'(vq[got].res));
                check($sformatf("stream r%0d flags", got), 64'(flags), 64'(vq[got].flg));
                got++;
                last_out = cyc;
            end else if (out_valid) begin
                check($sformatf("stall c%0d held result", cyc), 64'(result), 64'(vq[got].res));
            end
            if (in_valid && in_ready) issued++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream count", 64'(got), 64'd8);
        check("stream in_ready low cycles", 64'(ready_low), 64'd5);
        check("stream last result cycle", 64'(last_out), 64'd15);
    endtask

    task automatic reset_flight_test();
        for (int i = 0; i < 3; i++) begin
            a = vq[i].a; b = vq[i].b; op_sub = vq[i].op_sub;
            in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1; out_ready = 1'b0;
        a = vq[3].a; b = vq[3].b; op_sub = vq[3].op_sub; in_valid = 1'b1;
        @(posedge clk); #1;
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush result", 64'(result), 64'd0);
        check("flush flags", 64'(flags), 64'd0);
        check("flush in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check($sformatf("flush stale c%0d", i), 64'(out_valid), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        add_vec(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
        add_vec(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
        add_vec(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
        add_vec(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001);
        add_vec(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
        add_vec(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100);
        add_vec(32'h00400000, 32'h00400000, 1'b0, 32'h00800000, 3'b000);
        add_vec(32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 3'b000);
        add_vec(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000);
        add_vec(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
        add_vec(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000);
        add_vec(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000);
        add_vec(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
        add_vec(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000);
        add_vec(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000);
        add_vec(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000);
        add_vec(32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 3'b000);
        add_vec(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b001);
        add_vec(32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 3'b000);
        add_vec(32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 3'b000);
        add_vec(32'h00800001, 32'h00800000, 1'b1, 32'h00000001, 3'b000);
        add_vec(32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 3'b001);
        add_vec(32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 3'b001);

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op_sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset flags", 64'(flags), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vq.size(); i++) run_vec(i);

        stream_test();
        repeat (2) @(posedge clk);
        #1;
        reset_flight_test();
        run_vec(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
